// File: rtl/key_input_conditioner_pkg.sv
// rtl/key_input_conditioner_pkg.sv - shared constants for the key/switch input conditioner
package key_input_conditioner_pkg;

    localparam int CLK_HZ           = 50000000;
    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int NUM_KEYS_DEFAULT = 4;
    localparam int NUM_SW_DEFAULT   = 10;

endpackage

// File: rtl/key_input_conditioner_debounce_bit.sv
// rtl/key_input_conditioner_debounce_bit.sv - one-bit synchronizer, debouncer and edge pulse generator
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_q;
    logic             lvl_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Count consecutive cycles that the synchronized input disagrees with the level; accept on the last one
    always_comb begin
        cnt_d  = '0;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d  = sync2_q;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, counter, level and pulse registers; reset discards any count in progress
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = lvl_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/key_input_conditioner.sv
// rtl/key_input_conditioner.sv - debounced pushbutton and slide switch levels with edge pulses
module key_input_conditioner
    import key_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20,
    parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
    parameter int NUM_SW          = NUM_SW_DEFAULT
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_SW-1:0]   SW,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_SW-1:0]   sw_level,
    output logic                sw_change
);

    // Keys are wired active-low; flip them so everything downstream means "pressed"
    logic [NUM_KEYS-1:0] key_pressed_raw;
    logic [NUM_SW-1:0]   sw_rise;
    logic [NUM_SW-1:0]   sw_fall;
    logic                sw_change_q;
    logic                sw_change_d;

    assign key_pressed_raw = ~KEY;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk_i   (CLOCK_50),
            .reset_i (reset),
            .raw_i   (key_pressed_raw[gi]),
            .level_o (key_level[gi]),
            .rise_o  (key_press[gi]),
            .fall_o  (key_release[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk_i   (CLOCK_50),
            .reset_i (reset),
            .raw_i   (SW[gi]),
            .level_o (sw_level[gi]),
            .rise_o  (sw_rise[gi]),
            .fall_o  (sw_fall[gi])
        );
    end

    // Any switch settling this cycle collapses into one change strobe
    always_comb begin
        sw_change_d = |(sw_rise | sw_fall);
    end

    // Register the combined switch change strobe
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sw_change_q <= 1'b0;
        end else begin
            sw_change_q <= sw_change_d;
        end
    end

    assign sw_change = sw_change_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// tb/tb_key_input_conditioner.sv - self-checking bench for key_input_conditioner
module tb_key_input_conditioner;

    localparam int D  = 4;
    localparam int NK = 4;
    localparam int NS = 10;
    localparam int NB = NK + NS;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [NK-1:0] KEY;
    logic [NS-1:0] SW;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NS-1:0] sw_level;
    logic          sw_change;

    key_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .NUM_KEYS        (NK),
        .NUM_SW          (NS)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .KEY         (KEY),
        .SW          (SW),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_level    (sw_level),
        .sw_change   (sw_change)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a level flips once the last D synchronized samples all disagree with it
    logic [NB-1:0] m_d1, m_d2, m_lvl, m_rise, m_fall, m_s, m_diff;
    logic [NB-1:0] m_win [D];
    logic          m_swc;

    always @(posedge CLOCK_50) begin
        if (reset) begin
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_swc = 1'b0;
            for (int i = 0; i < D; i++) m_win[i] = '0;
        end else begin
            m_s  = m_d2;
            m_d2 = m_d1;
            m_d1 = {SW, ~KEY};
            for (int i = D - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = m_s;
            m_diff = '1;
            for (int i = 0; i < D; i++) m_diff = m_diff & (m_win[i] ^ m_lvl);
            m_swc  = |(m_rise[NB-1:NK] | m_fall[NB-1:NK]);
            m_rise = m_diff & ~m_lvl;
            m_fall = m_diff & m_lvl;
            m_lvl  = m_lvl ^ m_diff;
        end
    end

    int press_cnt [NK];
    int swc_cnt;

    task automatic tick();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_eq("key_level",   32'(key_level),   32'(m_lvl[NK-1:0]));
        check_eq("key_press",   32'(key_press),   32'(m_rise[NK-1:0]));
        check_eq("key_release", 32'(key_release), 32'(m_fall[NK-1:0]));
        check_eq("sw_level",    32'(sw_level),    32'(m_lvl[NB-1:NK]));
        check_eq("sw_change",   32'(sw_change),   32'(m_swc));
        check_eq("press_and_release", 32'(key_press & key_release), 32'd0);
        for (int i = 0; i < NK; i++) press_cnt[i] += int'(key_press[i]);
        swc_cnt += int'(sw_change);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_counts();
        for (int i = 0; i < NK; i++) press_cnt[i] = 0;
        swc_cnt = 0;
    endtask

    initial begin
        clr_counts();
        reset = 1'b1; KEY = 4'b0000; SW = 10'h3FF;
        // Reset holds everything low regardless of inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("reset_outputs", {key_level, key_press, key_release, sw_level, sw_change}, 32'd0);
        end

        // Held keys re-qualify after reset release
        reset = 1'b0; SW = 10'h000;
        ticks(5);
        check_eq("held_level_early", 32'(key_level), 32'h0);
        tick();
        check_eq("held_level", 32'(key_level), 32'hF);
        check_eq("held_press", 32'(key_press), 32'hF);
        tick();
        check_eq("held_press_once", 32'(key_press), 32'h0);

        // Clean press and release on KEY[1]
        KEY = 4'b1111;
        ticks(10);
        KEY = 4'b1101;
        ticks(5);
        check_eq("clean_press_early", 32'(key_press), 32'h0);
        tick();
        check_eq("clean_press", 32'(key_press), 32'h2);
        check_eq("clean_level", 32'(key_level), 32'h2);
        ticks(4);
        KEY = 4'b1111;
        ticks(6);
        check_eq("clean_release", 32'(key_release), 32'h2);
        tick();
        check_eq("clean_release_once", 32'(key_release), 32'h0);

        // Bounce on KEY[2] never qualifies, then a steady hold gives one press
        clr_counts();
        KEY = 4'b1011; ticks(2);
        KEY = 4'b1111; ticks(1);
        KEY = 4'b1011; ticks(3);
        KEY = 4'b1111; ticks(8);
        check_eq("bounce_no_press", 32'(press_cnt[2]), 32'd0);
        check_eq("bounce_level", 32'(key_level), 32'h0);
        KEY = 4'b1011; ticks(10);
        check_eq("bounce_then_hold", 32'(press_cnt[2]), 32'd1);
        KEY = 4'b1111; ticks(8);

        // Two switches settling together give one change strobe
        clr_counts();
        SW = 10'h005;
        ticks(6);
        check_eq("sw_level", 32'(sw_level), 32'h005);
        ticks(4);
        check_eq("sw_change_single", 32'(swc_cnt), 32'd1);

        // Reset mid-count discards progress on KEY[3]
        clr_counts();
        KEY = 4'b0111; ticks(4);
        check_eq("midcount_no_press", 32'(press_cnt[3]), 32'd0);
        reset = 1'b1; tick();
        reset = 1'b0;
        ticks(5);
        check_eq("midcount_early", 32'(press_cnt[3]), 32'd0);
        tick();
        check_eq("midcount_press", 32'(key_press), 32'h8);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 199));
            reset = (r < 3);
            if (r < 30) begin
                KEY = NK'($urandom);
                SW  = NS'($urandom);
            end else if (r < 70) begin
                int b;
                b = int'($urandom_range(0, NB - 1));
                if (b < NK) KEY[b] = ~KEY[b];
                else        SW[b-NK] = ~SW[b-NK];
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
